dcache_port_arbiter: RTL and testbench

// - Shares the single D-cache request port between the LSQ load-issue path and the SQ retire/store path.
// - Each requester has a one-entry holding register.
// - Arbitration is load-first, with a starvation counter that forces a waiting store through.
// - Squashes held loads on branch mispredict and applies branch-correct mask fixes.
// - Sits between the LSQ and the D-cache controller/MSHRs.

---
 rtl/dcache_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache request port between the load-issue and retired-store paths,
// with one-entry holds, load-first arbitration, store starvation guard and branch squash/fix.
module dcache_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 6,
    parameter int ROB_W      = 6,
    parameter int BRM_W      = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [TAG_W-1:0]  ld_dest_tag_i,
    input  logic [ROB_W-1:0]  ld_rob_idx_i,
    input  logic [BRM_W-1:0]  ld_br_mask_i,
    output logic              ld_rdy_o,
    input  logic              st_req_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic              st_rdy_o,
    output logic              dc_req_o,
    output logic              dc_is_st_o,
    output logic [ADDR_W-1:0] dc_addr_o,
    output logic [DATA_W-1:0] dc_data_o,
    output logic [TAG_W-1:0]  dc_dest_tag_o,
    output logic [ROB_W-1:0]  dc_rob_idx_o,
    output logic [BRM_W-1:0]  dc_br_mask_o,
    input  logic              dc_stall_i,
    input  logic              rob_br_recovery_i,
    input  logic              rob_br_pred_correct_i,
    input  logic [BRM_W-1:0]  rob_br_tag_fix_i
);

    typedef enum logic {PREFER_LD = 1'b0, PREFER_ST = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_starve_cnt, w_starve_nxt;

    logic              r_ld_vld;
    logic [ADDR_W-1:0] r_ld_addr;
    logic [TAG_W-1:0]  r_ld_tag;
    logic [ROB_W-1:0]  r_ld_rob;
    logic [BRM_W-1:0]  r_ld_br_mask;
    logic              r_st_vld;
    logic [ADDR_W-1:0] r_st_addr;
    logic [DATA_W-1:0] r_st_data;

    // Pick frozen by a stalled presentation; only a transfer or load squash releases it.
    logic              r_lock_vld;
    logic              r_lock_st;

    logic              w_sq_ld, w_in_sq, w_ld_ok;
    logic              w_pick_ld, w_pick_st, w_req, w_xfer;
    logic [BRM_W-1:0]  w_fix_mask;

    // Recovery wins over a coincident correct-resolution.
    assign w_fix_mask = (rob_br_pred_correct_i & ~rob_br_recovery_i) ? rob_br_tag_fix_i : '0;
    assign w_sq_ld    = rob_br_recovery_i & (|(r_ld_br_mask & rob_br_tag_fix_i));
    assign w_in_sq    = rob_br_recovery_i & (|(ld_br_mask_i & rob_br_tag_fix_i));
    assign w_ld_ok    = r_ld_vld & ~w_sq_ld;
    assign w_xfer     = w_req & ~dc_stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PREFER_LD;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_pick_ld    = 1'b0;
        w_pick_st    = 1'b0;
        w_req        = 1'b0;
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        if (r_lock_vld && r_lock_st) begin
            w_pick_st = 1'b1;
        end else if (r_lock_vld && w_ld_ok) begin
            w_pick_ld = 1'b1;
        end else if (r_state == PREFER_ST) begin
            w_pick_st = r_st_vld;
            w_pick_ld = ~r_st_vld & w_ld_ok;
        end else begin
            w_pick_ld = w_ld_ok;
            w_pick_st = ~w_ld_ok & r_st_vld;
        end
        w_req = (w_pick_ld | w_pick_st) & ~rst;
        if (w_req && !dc_stall_i && w_pick_st) begin
            w_starve_nxt = '0;
            w_state_nxt  = PREFER_LD;
        end else if (r_st_vld && w_req && w_pick_ld) begin
            if (r_starve_cnt != 4'hF) w_starve_nxt = r_starve_cnt + 4'd1;
            if (w_starve_nxt >= 4'(STARVE_MAX)) w_state_nxt = PREFER_ST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_vld   <= 1'b0;
            r_lock_st    <= 1'b0;
            r_ld_vld     <= 1'b0;
            r_ld_addr    <= '0;
            r_ld_tag     <= '0;
            r_ld_rob     <= '0;
            r_ld_br_mask <= '0;
            r_st_vld     <= 1'b0;
            r_st_addr    <= '0;
            r_st_data    <= '0;
        end else begin
            r_lock_vld <= w_req & dc_stall_i;
            r_lock_st  <= w_pick_st;
            if (r_ld_vld) begin
                if (w_sq_ld || (w_xfer && w_pick_ld)) r_ld_vld <= 1'b0;
                r_ld_br_mask <= r_ld_br_mask & ~w_fix_mask;
            end else if (ld_req_i && !w_in_sq) begin
                r_ld_vld     <= 1'b1;
                r_ld_addr    <= ld_addr_i;
                r_ld_tag     <= ld_dest_tag_i;
                r_ld_rob     <= ld_rob_idx_i;
                r_ld_br_mask <= ld_br_mask_i & ~w_fix_mask;
            end
            if (r_st_vld) begin
                if (w_xfer && w_pick_st) r_st_vld <= 1'b0;
            end else if (st_req_i) begin
                r_st_vld  <= 1'b1;
                r_st_addr <= st_addr_i;
                r_st_data <= st_data_i;
            end
        end
    end

    assign ld_rdy_o      = ~r_ld_vld;
    assign st_rdy_o      = ~r_st_vld;
    assign dc_req_o      = w_req;
    assign dc_is_st_o    = w_req & w_pick_st;
    assign dc_addr_o     = !w_req ? '0 : (w_pick_st ? r_st_addr : r_ld_addr);
    assign dc_data_o     = (w_req && w_pick_st) ? r_st_data : '0;
    assign dc_dest_tag_o = (w_req && w_pick_ld) ? r_ld_tag : '0;
    assign dc_rob_idx_o  = (w_req && w_pick_ld) ? r_ld_rob : '0;
    assign dc_br_mask_o  = (w_req && w_pick_ld) ? (r_ld_br_mask & ~w_fix_mask) : '0;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_dcache_port_arbiter;
    localparam int ADDR_W = 64, DATA_W = 64, TAG_W = 6, ROB_W = 6, BRM_W = 5, STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld_req_i = 1'b0;
    logic [ADDR_W-1:0] ld_addr_i = '0;
    logic [TAG_W-1:0]  ld_dest_tag_i = '0;
    logic [ROB_W-1:0]  ld_rob_idx_i = '0;
    logic [BRM_W-1:0]  ld_br_mask_i = '0;
    logic              ld_rdy_o;
    logic              st_req_i = 1'b0;
    logic [ADDR_W-1:0] st_addr_i = '0;
    logic [DATA_W-1:0] st_data_i = '0;
    logic              st_rdy_o;
    logic              dc_req_o, dc_is_st_o;
    logic [ADDR_W-1:0] dc_addr_o;
    logic [DATA_W-1:0] dc_data_o;
    logic [TAG_W-1:0]  dc_dest_tag_o;
    logic [ROB_W-1:0]  dc_rob_idx_o;
    logic [BRM_W-1:0]  dc_br_mask_o;
    logic              dc_stall_i = 1'b0;
    logic              rob_br_recovery_i = 1'b0;
    logic              rob_br_pred_correct_i = 1'b0;
    logic [BRM_W-1:0]  rob_br_tag_fix_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    dcache_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .ROB_W(ROB_W),
        .BRM_W(BRM_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_dest_tag_i(ld_dest_tag_i),
        .ld_rob_idx_i(ld_rob_idx_i), .ld_br_mask_i(ld_br_mask_i), .ld_rdy_o(ld_rdy_o),
        .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_rdy_o(st_rdy_o),
        .dc_req_o(dc_req_o), .dc_is_st_o(dc_is_st_o), .dc_addr_o(dc_addr_o),
        .dc_data_o(dc_data_o), .dc_dest_tag_o(dc_dest_tag_o), .dc_rob_idx_o(dc_rob_idx_o),
        .dc_br_mask_o(dc_br_mask_o), .dc_stall_i(dc_stall_i),
        .rob_br_recovery_i(rob_br_recovery_i), .rob_br_pred_correct_i(rob_br_pred_correct_i),
        .rob_br_tag_fix_i(rob_br_tag_fix_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each requester owns at most one pending item; choice 1 = load, 2 = store.
    bit                m_active = 1'b0;
    bit                m_ld_vld, m_st_vld, m_prefer_st;
    logic [ADDR_W-1:0] m_ld_addr, m_st_addr;
    logic [DATA_W-1:0] m_st_data;
    logic [TAG_W-1:0]  m_ld_tag;
    logic [ROB_W-1:0]  m_ld_rob;
    logic [BRM_W-1:0]  m_ld_mask;
    int                m_cnt, m_lock;

    always @(negedge clk) begin : model
        int choice;
        bit sq, ld_ok, req, xfer, corr;
        logic [BRM_W-1:0] clr;
        if (rst) begin
            if (m_active) begin
                check("rst_dc_req", dc_req_o, 0);
                check("rst_ld_rdy", ld_rdy_o, !m_ld_vld);
                check("rst_st_rdy", st_rdy_o, !m_st_vld);
            end
            m_ld_vld = 0; m_st_vld = 0; m_prefer_st = 0; m_cnt = 0; m_lock = 0;
            m_ld_addr = '0; m_st_addr = '0; m_st_data = '0;
            m_ld_tag = '0; m_ld_rob = '0; m_ld_mask = '0;
            m_active = 1'b1;
        end else if (m_active) begin
            corr  = rob_br_pred_correct_i && !rob_br_recovery_i;
            clr   = corr ? rob_br_tag_fix_i : '0;
            sq    = rob_br_recovery_i && ((m_ld_mask & rob_br_tag_fix_i) != 0);
            ld_ok = m_ld_vld && !sq;
            if (m_lock == 2) choice = 2;
            else if (m_lock == 1 && ld_ok) choice = 1;
            else if (m_prefer_st) choice = m_st_vld ? 2 : (ld_ok ? 1 : 0);
            else choice = ld_ok ? 1 : (m_st_vld ? 2 : 0);
            req  = (choice != 0);
            xfer = req && !dc_stall_i;

            check("ld_rdy", ld_rdy_o, !m_ld_vld);
            check("st_rdy", st_rdy_o, !m_st_vld);
            check("dc_req", dc_req_o, req);
            check("dc_is_st", dc_is_st_o, choice == 2);
            check("dc_addr", dc_addr_o, choice == 1 ? m_ld_addr : (choice == 2 ? m_st_addr : '0));
            check("dc_data", dc_data_o, choice == 2 ? m_st_data : '0);
            check("dc_tag", dc_dest_tag_o, choice == 1 ? m_ld_tag : '0);
            check("dc_rob", dc_rob_idx_o, choice == 1 ? m_ld_rob : '0);
            check("dc_mask", dc_br_mask_o, choice == 1 ? (m_ld_mask & ~clr) : '0);

            if (xfer && choice == 2) begin
                m_cnt = 0;
                m_prefer_st = 0;
            end else if (m_st_vld && choice == 1) begin
                if (m_cnt < 15) m_cnt++;
                if (m_cnt >= STARVE_MAX) m_prefer_st = 1;
            end
            m_lock = (req && dc_stall_i) ? choice : 0;

            if (m_ld_vld) begin
                if (sq || (xfer && choice == 1)) m_ld_vld = 0;
                m_ld_mask = m_ld_mask & ~clr;
            end else if (ld_req_i && !(rob_br_recovery_i && ((ld_br_mask_i & rob_br_tag_fix_i) != 0))) begin
                m_ld_vld = 1; m_ld_addr = ld_addr_i; m_ld_tag = ld_dest_tag_i;
                m_ld_rob = ld_rob_idx_i; m_ld_mask = ld_br_mask_i & ~clr;
            end
            if (m_st_vld) begin
                if (xfer && choice == 2) m_st_vld = 0;
            end else if (st_req_i) begin
                m_st_vld = 1; m_st_addr = st_addr_i; m_st_data = st_data_i;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_dc_req", dc_req_o, 0);
        check("idle_ld_rdy", ld_rdy_o, 1);
        check("idle_st_rdy", st_rdy_o, 1);

        // Single load, no stall
        step();
        ld_req_i = 1; ld_addr_i = 64'h100; ld_dest_tag_i = 6'd5; ld_rob_idx_i = 6'd7; ld_br_mask_i = '0;
        step();
        ld_req_i = 0;
        @(negedge clk);
        check("ld1_req", dc_req_o, 1);
        check("ld1_is_st", dc_is_st_o, 0);
        check("ld1_addr", dc_addr_o, 64'h100);
        check("ld1_tag", dc_dest_tag_o, 6'd5);
        check("ld1_rdy_busy", ld_rdy_o, 0);
        step();
        @(negedge clk);
        check("ld1_rdy_free", ld_rdy_o, 1);
        check("ld1_req_done", dc_req_o, 0);

        // Store blocked behind a stalled load until starvation, then store goes
        step();
        st_req_i = 1; st_addr_i = 64'h200; st_data_i = 64'hAB;
        ld_req_i = 1; ld_addr_i = 64'h140; ld_br_mask_i = '0; dc_stall_i = 1;
        step();
        st_req_i = 0; ld_req_i = 0;
        @(negedge clk);
        check("stv_ld_first", dc_addr_o, 64'h140);
        repeat (4) step();
        dc_stall_i = 0;
        @(negedge clk);
        check("stv_ld_still", dc_is_st_o, 0);
        step();
        @(negedge clk);
        check("stv_st_is_st", dc_is_st_o, 1);
        check("stv_st_addr", dc_addr_o, 64'h200);
        check("stv_st_data", dc_data_o, 64'hAB);
        step();
        @(negedge clk);
        check("stv_st_rdy", st_rdy_o, 1);

        // Stalled load squashed by recovery releases the port to the held store
        ld_req_i = 1; ld_addr_i = 64'h180; ld_br_mask_i = 5'b00010;
        st_req_i = 1; st_addr_i = 64'h300; st_data_i = 64'h33; dc_stall_i = 1;
        step();
        ld_req_i = 0; st_req_i = 0;
        @(negedge clk);
        check("sq_ld_pres", dc_addr_o, 64'h180);
        check("sq_ld_mask", dc_br_mask_o, 5'b00010);
        repeat (3) step();
        rob_br_recovery_i = 1; rob_br_tag_fix_i = 5'b00010;
        @(negedge clk);
        check("sq_req", dc_req_o, 1);
        check("sq_st_is_st", dc_is_st_o, 1);
        check("sq_st_addr", dc_addr_o, 64'h300);
        step();
        rob_br_recovery_i = 0; rob_br_tag_fix_i = '0; dc_stall_i = 0;
        @(negedge clk);
        check("sq_ld_dropped", ld_rdy_o, 1);
        check("sq_st_kept", dc_addr_o, 64'h300);
        step();

        // Branch-correct mask fix on a held load
        ld_req_i = 1; ld_addr_i = 64'h1C0; ld_br_mask_i = 5'b00110; dc_stall_i = 1;
        step();
        ld_req_i = 0;
        rob_br_pred_correct_i = 1; rob_br_tag_fix_i = 5'b00100;
        @(negedge clk);
        check("fix_mask_now", dc_br_mask_o, 5'b00010);
        step();
        rob_br_pred_correct_i = 0; rob_br_tag_fix_i = '0;
        @(negedge clk);
        check("fix_mask_held", dc_br_mask_o, 5'b00010);
        dc_stall_i = 0;
        step();

        // Reset while a store is stalled
        st_req_i = 1; st_addr_i = 64'h400; st_data_i = 64'h44; dc_stall_i = 1;
        step();
        st_req_i = 0;
        @(negedge clk);
        check("rs_st_pres", dc_addr_o, 64'h400);
        repeat (5) step();
        rst = 1;
        @(negedge clk);
        check("rs_req_in_rst", dc_req_o, 0);
        step();
        rst = 0; dc_stall_i = 0;
        @(negedge clk);
        check("rs_req_after", dc_req_o, 0);
        check("rs_st_rdy", st_rdy_o, 1);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step();
            rst                   = ($urandom_range(0, 199) == 0);
            ld_req_i              = ($urandom_range(0, 9) < 6);
            ld_addr_i             = {$urandom, $urandom};
            ld_dest_tag_i         = 6'($urandom);
            ld_rob_idx_i          = 6'($urandom);
            ld_br_mask_i          = 5'($urandom);
            st_req_i              = ($urandom_range(0, 1) == 0);
            st_addr_i             = {$urandom, $urandom};
            st_data_i             = {$urandom, $urandom};
            dc_stall_i            = ($urandom_range(0, 2) == 0);
            rob_br_recovery_i     = ($urandom_range(0, 15) == 0);
            rob_br_pred_correct_i = ($urandom_range(0, 7) == 0);
            rob_br_tag_fix_i      = 5'(1 << $urandom_range(0, 4));
        end
        step();
        rst = 0; ld_req_i = 0; st_req_i = 0; dc_stall_i = 0;
        rob_br_recovery_i = 0; rob_br_pred_correct_i = 0;
        repeat (3) step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
